// File: rtl/rr_rate_monitor.sv
// RR-interval validator, 16-bit restoring-divider heart-rate calculator and N-interval running average.
// Optional brady/tachy alarm flags are built only when HR_ALARM_EN is defined.
module rr_rate_monitor #(
  parameter int DATA_WIDTH = 11,
  parameter int FS_HZ      = 360,
  parameter int N_AVG      = 8,
  parameter int BPM_WIDTH  = 8,
  parameter int RR_MIN     = 72,
  parameter int BRADY_BPM  = 50,
  parameter int TACHY_BPM  = 120
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_rr_period,
  input  logic                  i_rr_period_updated,
  output logic [BPM_WIDTH-1:0]  o_bpm,
  output logic                  o_bpm_valid,
  output logic [DATA_WIDTH-1:0] o_rr_avg,
  output logic                  o_rr_avg_valid,
  output logic                  o_busy,
  output logic                  o_rr_reject,
  output logic                  o_overrun,
  output logic                  o_brady,
  output logic                  o_tachy
);

  localparam int AW    = $clog2(N_AVG);
  localparam int SUM_W = DATA_WIDTH + AW;
  localparam int Q     = 16;
  localparam int CW    = $clog2(Q);
  localparam logic [Q-1:0] DIVIDEND = Q'(60 * FS_HZ);
  localparam logic [Q-1:0] BPM_MAX  = Q'((1 << BPM_WIDTH) - 1);

  if ((N_AVG < 2) || (N_AVG > 64) || ((1 << AW) != N_AVG) || (BPM_WIDTH > Q)
      || (BRADY_BPM >= TACHY_BPM)) begin : g_bad_cfg
    $error("rr_rate_monitor: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                 state;
  state_t                 next_state;
  logic [DATA_WIDTH-1:0]  rr_buf [N_AVG];
  logic [AW-1:0]          wr_ptr;
  logic [SUM_W-1:0]       sum;
  logic [SUM_W-1:0]       new_sum;
  logic [AW:0]            fill;
  logic                   avg_full_next;
  logic [Q-1:0]           quot;
  logic [DATA_WIDTH-1:0]  rem;
  logic [DATA_WIDTH-1:0]  divisor;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH:0]    shifted;
  logic [DATA_WIDTH-1:0]  diff;
  logic                   fits;
  logic [BPM_WIDTH-1:0]   bpm_sat;
  logic                   rr_low;
  logic                   accept;
  logic                   div_step;
  logic                   div_finish;

  always_comb begin
    rr_low        = (i_rr_period == '0) || (i_rr_period < DATA_WIDTH'(RR_MIN));
    accept        = i_rr_period_updated && !rr_low && (state == IDLE);
    new_sum       = sum - SUM_W'(rr_buf[wr_ptr]) + SUM_W'(i_rr_period);
    avg_full_next = (fill >= (AW+1)'(N_AVG - 1));
    // The remainder is always below the divisor, so only its low bits matter after subtracting.
    shifted       = {rem, quot[Q-1]};
    fits          = (shifted >= {1'b0, divisor});
    diff          = shifted[DATA_WIDTH-1:0] - divisor;
    bpm_sat       = (quot > BPM_MAX) ? BPM_MAX[BPM_WIDTH-1:0] : quot[BPM_WIDTH-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else if (i_ce) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = DIV;
      DIV:     if (bit_cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = 1'b0;
    div_step   = 1'b0;
    div_finish = 1'b0;
    case (state)
      DIV: begin
        o_busy   = 1'b1;
        div_step = 1'b1;
      end
      DONE: begin
        o_busy     = 1'b1;
        div_finish = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_AVG; i++) rr_buf[i] <= '0;
      wr_ptr         <= '0;
      sum            <= '0;
      fill           <= '0;
      o_rr_avg       <= '0;
      o_rr_avg_valid <= 1'b0;
      quot           <= '0;
      rem            <= '0;
      divisor        <= '0;
      bit_cnt        <= '0;
      o_bpm          <= '0;
      o_bpm_valid    <= 1'b0;
      o_rr_reject    <= 1'b0;
      o_overrun      <= 1'b0;
    end else if (i_ce) begin
      o_bpm_valid <= 1'b0;
      o_rr_reject <= i_rr_period_updated && rr_low;
      o_overrun   <= i_rr_period_updated && !rr_low && (state != IDLE);
      if (accept) begin
        rr_buf[wr_ptr] <= i_rr_period;
        wr_ptr         <= wr_ptr + 1'b1;
        sum            <= new_sum;
        if (fill != (AW+1)'(N_AVG)) fill <= fill + 1'b1;
        o_rr_avg_valid <= avg_full_next;
        o_rr_avg       <= avg_full_next ? DATA_WIDTH'(new_sum >> AW) : '0;
        quot           <= DIVIDEND;
        rem            <= '0;
        divisor        <= i_rr_period;
        bit_cnt        <= CW'(Q - 1);
      end
      if (div_step) begin
        rem     <= fits ? diff : shifted[DATA_WIDTH-1:0];
        quot    <= {quot[Q-2:0], fits};
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (div_finish) begin
        o_bpm       <= bpm_sat;
        o_bpm_valid <= 1'b1;
      end
    end
  end

`ifdef HR_ALARM_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_brady <= 1'b0;
      o_tachy <= 1'b0;
    end else if (i_ce && div_finish) begin
      o_brady <= (bpm_sat < BPM_WIDTH'(BRADY_BPM));
      o_tachy <= (bpm_sat > BPM_WIDTH'(TACHY_BPM));
    end
  end
`else
  assign o_brady = 1'b0;
  assign o_tachy = 1'b0;
`endif

endmodule

// File: tb/tb_rr_rate_monitor.sv
// Scoreboard bench for rr_rate_monitor: directed scenarios plus randomized strobes/clock-enable,
// checked against an arithmetic reference model of the rate/average/strobe rules.
module tb_rr_rate_monitor;

  localparam int DW        = 11;
  localparam int FS_HZ     = 360;
  localparam int N_AVG     = 8;
  localparam int BW        = 8;
  localparam int RR_MIN    = 72;
  localparam int BRADY_BPM = 50;
  localparam int TACHY_BPM = 120;
  localparam int LAT       = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce  = 1'b0;
  logic          upd = 1'b0;
  logic [DW-1:0] rr  = '0;
  logic [BW-1:0] o_bpm;
  logic          o_bpm_valid;
  logic [DW-1:0] o_rr_avg;
  logic          o_rr_avg_valid;
  logic          o_busy;
  logic          o_rr_reject;
  logic          o_overrun;
  logic          o_brady;
  logic          o_tachy;

  always #5 clk = ~clk;

  rr_rate_monitor #(
    .DATA_WIDTH(DW), .FS_HZ(FS_HZ), .N_AVG(N_AVG), .BPM_WIDTH(BW),
    .RR_MIN(RR_MIN), .BRADY_BPM(BRADY_BPM), .TACHY_BPM(TACHY_BPM)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_rr_period(rr), .i_rr_period_updated(upd),
    .o_bpm(o_bpm), .o_bpm_valid(o_bpm_valid), .o_rr_avg(o_rr_avg),
    .o_rr_avg_valid(o_rr_avg_valid), .o_busy(o_busy), .o_rr_reject(o_rr_reject),
    .o_overrun(o_overrun), .o_brady(o_brady), .o_tachy(o_tachy)
  );

  typedef struct {
    int edge_no;
    int bpm;
    int avg;
    bit avgv;
    bit brady;
    bit tachy;
  } bpm_ev_t;

  int      checks   = 0;
  int      failures = 0;
  int      ce_edges = 0;
  bit      started  = 1'b0;

  bpm_ev_t bpm_q[$];
  int      rej_q[$];
  int      ovr_q[$];

  int      acc_edge    = 0;
  bit      busy_active = 1'b0;
  int      hist[$];
  int      n_acc    = 0;
  int      last_bpm = 0;

  bpm_ev_t mon_ev;
  int      mon_e;
  int      mon_x;
  bit      exp_busy;

  // Counts every enabled edge; the model timestamps events in these units.
  always @(posedge clk) if (ce) ce_edges <= ce_edges + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model of one sampled strobe at enabled edge e.
  task automatic modelStrobe(input int v, input int e);
    bpm_ev_t ev;
    int      s;
    int      q;
    if (v < RR_MIN) begin
      rej_q.push_back(e);
    end else if (busy_active && e <= acc_edge + LAT) begin
      ovr_q.push_back(e);
    end else begin
      acc_edge    = e;
      busy_active = 1'b1;
      hist.push_back(v);
      if (hist.size() > N_AVG) void'(hist.pop_front());
      n_acc++;
      s = 0;
      foreach (hist[i]) s += hist[i];
      q = (60 * FS_HZ) / v;
      ev.edge_no = e + LAT;
      ev.bpm     = (q > 255) ? 255 : q;
      ev.avgv    = (n_acc >= N_AVG);
      ev.avg     = ev.avgv ? s / N_AVG : 0;
`ifdef HR_ALARM_EN
      ev.brady = (ev.bpm < BRADY_BPM);
      ev.tachy = (ev.bpm > TACHY_BPM);
`else
      ev.brady = 1'b0;
      ev.tachy = 1'b0;
`endif
      bpm_q.push_back(ev);
    end
  endtask

  task automatic applyStimulus(input int v, input bit u, input bit c);
    rr  = DW'(v);
    upd = u;
    ce  = c;
    rst = 1'b0;
    if (u && c) modelStrobe(v, ce_edges + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    ce  = 1'b1;
    upd = 1'b0;
    bpm_q.delete();
    rej_q.delete();
    ovr_q.delete();
    hist.delete();
    busy_active = 1'b0;
    n_acc       = 0;
    last_bpm    = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_bpm"}, o_bpm, 0);
    checkOutput({tag, "_bpm_valid"}, o_bpm_valid, 0);
    checkOutput({tag, "_avg"}, o_rr_avg, 0);
    checkOutput({tag, "_avg_valid"}, o_rr_avg_valid, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_reject"}, o_rr_reject, 0);
    checkOutput({tag, "_overrun"}, o_overrun, 0);
    checkOutput({tag, "_brady"}, o_brady, 0);
    checkOutput({tag, "_tachy"}, o_tachy, 0);
  endtask

  // Monitor: each enabled cycle shows the result of the latest enabled edge exactly once.
  always @(negedge clk) begin
    if (started && !rst && ce) begin
      mon_e    = ce_edges;
      exp_busy = busy_active && (mon_e >= acc_edge) && (mon_e <= acc_edge + LAT - 1);
      checkOutput("busy", o_busy, exp_busy);
      if (o_bpm_valid) begin
        if (bpm_q.size() == 0) begin
          checkOutput("bpm_valid_unexpected", 1, 0);
        end else begin
          mon_ev = bpm_q.pop_front();
          checkOutput("bpm_latency_edge", mon_e, mon_ev.edge_no);
          checkOutput("bpm_value", o_bpm, mon_ev.bpm);
          checkOutput("rr_avg", o_rr_avg, mon_ev.avg);
          checkOutput("rr_avg_valid", o_rr_avg_valid, mon_ev.avgv);
          checkOutput("brady", o_brady, mon_ev.brady);
          checkOutput("tachy", o_tachy, mon_ev.tachy);
          last_bpm = mon_ev.bpm;
        end
      end else begin
        checkOutput("bpm_hold", o_bpm, last_bpm);
      end
      if (o_rr_reject) begin
        if (rej_q.size() == 0) checkOutput("reject_unexpected", 1, 0);
        else begin
          mon_x = rej_q.pop_front();
          checkOutput("reject_edge", mon_e, mon_x);
        end
      end
      if (o_overrun) begin
        if (ovr_q.size() == 0) checkOutput("overrun_unexpected", 1, 0);
        else begin
          mon_x = ovr_q.pop_front();
          checkOutput("overrun_edge", mon_e, mon_x);
        end
      end
    end
  end

  initial begin
    int v;
    bit u;
    bit c;
    #2;
    doReset();
    started = 1'b1;
    checkResetState("reset");

    applyStimulus(360, 1'b1, 1'b1);
    idle(22);
    checkOutput("bpm_360", o_bpm, 60);
    applyStimulus(100, 1'b1, 1'b1);
    idle(22);
    checkOutput("bpm_100", o_bpm, 216);
    applyStimulus(500, 1'b1, 1'b1);
    idle(22);
    checkOutput("bpm_500", o_bpm, 43);

    applyStimulus(50, 1'b1, 1'b1);
    idle(2);
    applyStimulus(0, 1'b1, 1'b1);
    idle(2);
    checkOutput("avg_valid_after_reject", o_rr_avg_valid, 0);
    applyStimulus(72, 1'b1, 1'b1);
    idle(22);
    checkOutput("bpm_72_saturated", o_bpm, 255);

    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(300, 1'b1, 1'b1);
      idle(18);
    end
    checkOutput("avg_300", o_rr_avg, 300);
    checkOutput("avg_valid_300", o_rr_avg_valid, 1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(400, 1'b1, 1'b1);
      idle(18);
    end
    checkOutput("avg_400", o_rr_avg, 400);

    applyStimulus(360, 1'b1, 1'b1);
    idle(4);
    applyStimulus(200, 1'b1, 1'b1);
    idle(22);
    applyStimulus(200, 1'b1, 1'b1);
    idle(22);

    applyStimulus(360, 1'b1, 1'b1);
    for (int k = 0; k < 80; k++) applyStimulus(0, 1'b0, (k % 4) == 3);
    idle(4);
    checkOutput("bpm_360_ce_gated", o_bpm, 60);

    applyStimulus(360, 1'b1, 1'b1);
    idle(6);
    doReset();
    checkResetState("mid_div_reset");
    idle(3);
    applyStimulus(250, 1'b1, 1'b1);
    idle(22);
    checkOutput("bpm_250_after_reset", o_bpm, 86);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset();
      end else begin
        c = ($urandom_range(0, 3) != 0);
        u = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) v = $urandom_range(0, 90);
        else v = $urandom_range(60, 2047);
        applyStimulus(v, u, c);
      end
    end
    idle(40);

    checkOutput("pending_bpm_events", bpm_q.size(), 0);
    checkOutput("pending_reject_events", rej_q.size(), 0);
    checkOutput("pending_overrun_events", ovr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_rate_monitor.md
Name: rr_rate_monitor

Overview:
- Downstream consumer of the detection core's RR-interval output (`rr_period`, `rr_period_updated`).
- Validates each new RR interval and converts it to an instantaneous heart rate in BPM using a sequential restoring divider.
- Keeps an N-interval running average of accepted RR values.
- Feeds the display/telemetry stage with rate, average and alarm flags.

Parameters:
- DATA_WIDTH, 11, width of RR period in samples
- FS_HZ, 360, ECG sample rate in Hz; dividend = 60*FS_HZ
- N_AVG, 8, RR averaging depth; power of two, 2..64
- BPM_WIDTH, 8, BPM output width
- RR_MIN, 72, smallest accepted RR in samples (300 BPM at 360 Hz)
- BRADY_BPM, 50, bradycardia threshold
- TACHY_BPM, 120, tachycardia threshold

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active high
- i_ce  in  1  clock enable
- i_rr_period  in  DATA_WIDTH  RR interval in samples
- i_rr_period_updated  in  1  one-cycle strobe, RR value valid
- o_bpm  out  BPM_WIDTH  last computed heart rate
- o_bpm_valid  out  1  one-cycle strobe, o_bpm updated
- o_rr_avg  out  DATA_WIDTH  mean of last N_AVG accepted RR
- o_rr_avg_valid  out  1  level; high once N_AVG values accepted
- o_busy  out  1  divider active
- o_rr_reject  out  1  one-cycle strobe, RR out of range
- o_overrun  out  1  one-cycle strobe, update dropped while busy
- o_brady  out  1  rate below BRADY_BPM (optional)
- o_tachy  out  1  rate above TACHY_BPM (optional)

Behaviour:
- Interface: one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- Reset: all outputs, the buffer, the sum, the fill count, the write pointer and the FSM are cleared to 0 / IDLE. Reset overrides `i_ce` and aborts any division in progress; no `o_bpm_valid` follows.
- `i_ce` gating: all state advances only on edges with `i_ce` = 1. Strobes are asserted for exactly one `i_ce` cycle.
- Acceptance: the strobe is sampled only when `i_ce` = 1.
  - If the RR is 0 or below RR_MIN: pulse `o_rr_reject`; buffer and FSM are unchanged.
  - Else if the FSM is not IDLE: pulse `o_overrun`; the value is dropped (neither buffered nor divided).
  - Else: accept.
- Running average:
  - On accept, write into a circular buffer at wr_ptr; wr_ptr wraps modulo N_AVG.
  - sum <= sum - buf[wr_ptr] + rr. The sum is DATA_WIDTH+log2(N_AVG) bits and never overflows.
  - The fill count saturates at N_AVG. `o_rr_avg_valid` rises on the edge of the N_AVG-th accept and stays high until reset.
  - `o_rr_avg` = sum >> log2(N_AVG), registered; it reads 0 while not valid.
- Divider FSM: IDLE -> DIV -> DONE -> IDLE; internal quotient width Q = 16 bits.
  - Accept edge (edge 0): load dividend 60*FS_HZ and divisor rr; bit counter = Q-1; go to DIV; `o_busy` = 1.
  - DIV: one restoring iteration per `i_ce` edge, edges 1..Q. After the iteration with counter 0, go to DONE.
  - DONE (edge Q+1): `o_bpm` <= min(quotient, 2^BPM_WIDTH-1), i.e. saturating; `o_bpm_valid` pulses; `o_busy` drops; go to IDLE.
  - Latency: `o_bpm_valid` is high in the cycle following the 17th `i_ce` edge after the accept edge.
  - The quotient truncates (floor). `o_bpm` holds its value between updates.
- Simultaneous events:
  - An update arriving on the DONE edge is dropped with `o_overrun`, since `o_busy` is still high.
  - A reject and an overrun are never both asserted; the range check has priority.

Optional Feature:
- Macro HR_ALARM_EN.
- Defined:
  - `o_brady` is registered with `o_bpm_valid`: high when the new bpm < BRADY_BPM.
  - `o_tachy` is registered with `o_bpm_valid`: high when the new bpm > TACHY_BPM.
  - Both flags hold until the next `o_bpm_valid` or reset.
- Undefined: `o_brady` and `o_tachy` are tied to 0 and no comparator logic is generated.

Test Plan:
- rr=360, `i_ce`=1 constant -> `o_busy` high for 17 cycles; `o_bpm`=60 with `o_bpm_valid` on the 17th cycle after the strobe; `o_brady`=`o_tachy`=0.
- rr=100 -> `o_bpm`=216, `o_tachy`=1 with HR_ALARM_EN. rr=500 -> `o_bpm`=43, `o_brady`=1.
- rr=50 and rr=0 -> `o_rr_reject` pulse each; no `o_busy`; average state unchanged. rr=72 -> `o_bpm`=255 (300 saturated, not rejected).
- 8 accepts of 300 -> `o_rr_avg_valid` rises on the 8th accept, `o_rr_avg`=300. Then 8 accepts of 400 -> `o_rr_avg` steps through 312, 325, …, 400 (wrap-around verified).
- Second strobe 5 cycles after an accept -> `o_overrun` pulse; exactly one `o_bpm_valid`; the average counts only one value.
- `i_ce` toggling 1-of-4 during division -> identical `o_bpm`, latency 17 enabled edges. Assert `i_rst` mid-DIV -> all outputs 0 next edge, no `o_bpm_valid`; a new accept after release works.
